// File: rtl/pkg_memory.sv
// Shared sizing and types for the kernel memory loader.
// Contents: memory/DRAM geometry, gearbox width, loader FSM states, beat-count helper.
package pkg_memory;

    localparam int unsigned KER_NUM        = 3;
    localparam int unsigned KER_WIDTH_MAX  = 75;
    localparam int unsigned KER_HEIGHT_MAX = 1920;
    localparam int unsigned DRAM_DATA_BITS = 512;
    localparam int unsigned DRAM_ADDR_BITS = 29;

    // Worst case: 74 residual bits plus one fresh beat.
    localparam int unsigned GBX_BITS = KER_WIDTH_MAX - 1 + DRAM_DATA_BITS;

    localparam int unsigned WORD_CNT_BITS = 11;
    localparam int unsigned BEAT_CNT_BITS = 9;
    localparam int unsigned FILL_CNT_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } ldr_state_t;

    // ceil(words * 75 / 512). The product needs 18 bits: 1920 * 75 = 144000.
    function automatic logic [BEAT_CNT_BITS-1:0] beats_for_words(
        input logic [WORD_CNT_BITS-1:0] words
    );
        logic [17:0] prod;
        prod = 18'(words) * 18'(KER_WIDTH_MAX);
        return BEAT_CNT_BITS'((prod + 18'(DRAM_DATA_BITS - 1)) >> $clog2(DRAM_DATA_BITS));
    endfunction

endpackage

// File: rtl/kernel_gearbox.sv
// Width converter: 512-bit DRAM beats in, 75-bit kernel words out, LSB-first.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   run             load in progress; when low all fill/count state is cleared
//   beats, words    totals for the current load
//   in_data/valid   DRAM response beat; in_ready accepts it
//   out_en/addr/data registered word write; out_last marks the final word
module kernel_gearbox
    import pkg_memory::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [BEAT_CNT_BITS-1:0]  beats,
    input  logic [WORD_CNT_BITS-1:0]  words,
    input  logic [DRAM_DATA_BITS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_en,
    output logic [WORD_CNT_BITS-1:0]  out_addr,
    output logic [KER_WIDTH_MAX-1:0]  out_data,
    output logic                      out_last
);

    logic [GBX_BITS-1:0]      sr_q, sr_d;
    logic [FILL_CNT_BITS-1:0] fill_q, fill_d;
    logic [BEAT_CNT_BITS-1:0] accepted_q, accepted_d;
    logic [WORD_CNT_BITS-1:0] written_q, written_d;
    logic                     out_en_q, out_en_d;
    logic [WORD_CNT_BITS-1:0] out_addr_q, out_addr_d;
    logic [KER_WIDTH_MAX-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     emit;

    always_comb begin
        in_ready = run && (fill_q < FILL_CNT_BITS'(KER_WIDTH_MAX)) && (accepted_q < beats);
        emit     = run && (fill_q >= FILL_CNT_BITS'(KER_WIDTH_MAX)) && (written_q < words);

        sr_d       = sr_q;
        fill_d     = fill_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        out_en_d   = 1'b0;
        out_last_d = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        if (!run) begin
            // Drops any tail bits left after the final word.
            sr_d       = '0;
            fill_d     = '0;
            accepted_d = '0;
            written_d  = '0;
        end else if (in_ready && in_valid) begin
            // Bits above fill_q are always zero, so OR-in appends the beat.
            sr_d       = sr_q | (GBX_BITS'(in_data) << fill_q);
            fill_d     = fill_q + FILL_CNT_BITS'(DRAM_DATA_BITS);
            accepted_d = accepted_q + 1'b1;
        end else if (emit) begin
            out_en_d   = 1'b1;
            out_data_d = sr_q[KER_WIDTH_MAX-1:0];
            out_addr_d = written_q;
            out_last_d = (written_q == words - 1'b1);
            sr_d       = sr_q >> KER_WIDTH_MAX;
            fill_d     = fill_q - FILL_CNT_BITS'(KER_WIDTH_MAX);
            written_d  = written_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            fill_q     <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_en   = out_en_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;

endmodule

// File: rtl/kernel_dram_loader.sv
// DRAM-to-kernel-BRAM fill engine: reads `beats` contiguous 512-bit DRAM beats from
// dram_base and writes word_cnt 75-bit words to kernel memory ker_sel, addresses 0..N-1.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start/ker_sel/dram_base/word_cnt   load command (sampled in IDLE only)
//   busy, done, err            status (done/err are one-cycle pulses)
//   dram_rd_*                  DRAM read request and in-order response channel
//   ker_wr_*                   kernel memory write port, one-hot enable
//   ker_csum                   XOR of words written this load (KER_LOAD_CHECKSUM_EN only)
// Optional feature macro: KER_LOAD_CHECKSUM_EN.
module kernel_dram_loader
    import pkg_memory::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                ker_sel,
    input  logic [DRAM_ADDR_BITS-1:0] dram_base,
    input  logic [WORD_CNT_BITS-1:0]  word_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DRAM_ADDR_BITS-1:0] dram_rd_addr,
    output logic                      dram_rd_req,
    input  logic                      dram_rd_ack,
    input  logic [DRAM_DATA_BITS-1:0] dram_rd_data,
    input  logic                      dram_rd_valid,
    output logic                      dram_rd_ready,
    output logic [KER_NUM-1:0]        ker_wr_en,
    output logic [WORD_CNT_BITS-1:0]  ker_wr_addr,
    output logic [KER_WIDTH_MAX-1:0]  ker_wr_data
`ifdef KER_LOAD_CHECKSUM_EN
    ,
    output logic [KER_WIDTH_MAX-1:0]  ker_csum
`endif
);

    ldr_state_t                state_q, state_d;
    logic [1:0]                sel_q, sel_d;
    logic [DRAM_ADDR_BITS-1:0] base_q, base_d;
    logic [WORD_CNT_BITS-1:0]  words_q, words_d;
    logic [BEAT_CNT_BITS-1:0]  beats_q, beats_d;
    logic [BEAT_CNT_BITS-1:0]  issued_q, issued_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      start_ok;
    logic                      gbx_en;
    logic                      gbx_last;

    always_comb begin
        start_ok = (word_cnt != '0) && (word_cnt <= WORD_CNT_BITS'(KER_HEIGHT_MAX))
                   && (ker_sel < 2'(KER_NUM));

        state_d  = state_q;
        sel_d    = sel_q;
        base_d   = base_q;
        words_d  = words_q;
        beats_d  = beats_q;
        issued_d = issued_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        sel_d    = ker_sel;
                        base_d   = dram_base;
                        words_d  = word_cnt;
                        beats_d  = beats_for_words(word_cnt);
                        issued_d = '0;
                        busy_d   = 1'b1;
                        state_d  = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dram_rd_req && dram_rd_ack) begin
                    issued_d = issued_q + 1'b1;
                end
                // Requests may be long finished; completion is gated on the last write.
                if (gbx_en && gbx_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            base_q   <= '0;
            words_q  <= '0;
            beats_q  <= '0;
            issued_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            base_q   <= base_d;
            words_q  <= words_d;
            beats_q  <= beats_d;
            issued_q <= issued_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dram_rd_req  = (state_q == REQ) && (issued_q < beats_q);
    // Wraps modulo 2^29 by width.
    assign dram_rd_addr = base_q + DRAM_ADDR_BITS'(issued_q);

    kernel_gearbox u_gearbox (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state_q == REQ),
        .beats    (beats_q),
        .words    (words_q),
        .in_data  (dram_rd_data),
        .in_valid (dram_rd_valid),
        .in_ready (dram_rd_ready),
        .out_en   (gbx_en),
        .out_addr (ker_wr_addr),
        .out_data (ker_wr_data),
        .out_last (gbx_last)
    );

    assign ker_wr_en = gbx_en ? (KER_NUM'(1) << sel_q) : '0;

`ifdef KER_LOAD_CHECKSUM_EN
    logic [KER_WIDTH_MAX-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start && start_ok) begin
            csum_d = '0;
        end else if (gbx_en) begin
            csum_d = csum_q ^ ker_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign ker_csum = csum_q;
`endif

endmodule
